// File: rtl/reg_access_master.sv
// reg_access_master
//   Initiator for the byte-wide register-file access protocol. Takes one
//   read/write command at a time from an upstream source, drives the address
//   and data phases against the register block with read/write strobes, and
//   returns a single-cycle response carrying read data or an error flag.
//
// Parameters
//   TIMEOUT   cycles to wait on any reg_valid edge before aborting (>= 2)
//   MAX_ADDR  highest address the register block acknowledges
//
// Ports
//   clk, nRst            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (accepted when both high)
//   cmd_rnw              1 = read, 0 = write
//   cmd_addr, cmd_wdata  register address and write data
//   reg_bus              address during the strobe, then write data
//   reg_read, reg_write  access strobes (never high together)
//   reg_rdata, reg_valid register block read data and acknowledge
//   rsp_valid            one-cycle response pulse
//   rsp_rnw, rsp_data    echoed direction and read data (0 for writes/errors)
//   rsp_err              address out of range or timeout
module reg_access_master #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [7:0]  MAX_ADDR = 8'd254
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rnw,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic [7:0] reg_bus,
    output logic       reg_read,
    output logic       reg_write,
    input  logic [7:0] reg_rdata,
    input  logic       reg_valid,
    output logic       rsp_valid,
    output logic       rsp_rnw,
    output logic [7:0] rsp_data,
    output logic       rsp_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        W_ADDR,
        W_DATA,
        R_ADDR,
        R_REL,
        RESP
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          lat_rnw, lat_rnw_d;
    logic [7:0]    lat_wdata, lat_wdata_d;

    logic          cmd_ready_d, reg_read_d, reg_write_d;
    logic          rsp_valid_d, rsp_rnw_d, rsp_err_d;
    logic [7:0]    reg_bus_d, rsp_data_d;

    logic          timeout_hit;
    logic          finish;
    logic          abort;

    // Every output is a register; the combinational block only computes
    // their next values, so the response is raised on the same edge that
    // enters RESP and is therefore visible during the RESP cycle.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_rnw   <= 1'b0;
            lat_wdata <= '0;
            cmd_ready <= 1'b1;
            reg_bus   <= '0;
            reg_read  <= 1'b0;
            reg_write <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rnw   <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            lat_rnw   <= lat_rnw_d;
            lat_wdata <= lat_wdata_d;
            cmd_ready <= cmd_ready_d;
            reg_bus   <= reg_bus_d;
            reg_read  <= reg_read_d;
            reg_write <= reg_write_d;
            rsp_valid <= rsp_valid_d;
            rsp_rnw   <= rsp_rnw_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        lat_rnw_d   = lat_rnw;
        lat_wdata_d = lat_wdata;
        cmd_ready_d = cmd_ready;
        reg_bus_d   = reg_bus;
        reg_read_d  = reg_read;
        reg_write_d = reg_write;
        rsp_valid_d = rsp_valid;
        rsp_rnw_d   = rsp_rnw;
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;
        finish      = 1'b0;
        abort       = 1'b0;

        // cnt counts completed cycles in the current wait state, so the
        // strobe is held for exactly TIMEOUT cycles before giving up.
        timeout_hit = (32'(cnt) + 32'd1) >= TIMEOUT;

        case (state)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid) begin
                    cmd_ready_d = 1'b0;
                    lat_rnw_d   = cmd_rnw;
                    lat_wdata_d = cmd_wdata;
                    if (cmd_addr > MAX_ADDR) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rnw_d   = cmd_rnw;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b1;
                    end else if (cmd_rnw) begin
                        reg_bus_d  = cmd_addr;
                        reg_read_d = 1'b1;
                        state_d    = R_ADDR;
                    end else begin
                        reg_bus_d   = cmd_addr;
                        reg_write_d = 1'b1;
                        state_d     = W_ADDR;
                    end
                end
            end
            W_ADDR: begin
                if (reg_valid) begin
                    reg_write_d = 1'b0;
                    reg_bus_d   = lat_wdata;
                    state_d     = W_DATA;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            W_DATA: begin
                if (!reg_valid) begin
                    finish = 1'b1;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            R_ADDR: begin
                if (reg_valid) begin
                    rsp_data_d = reg_rdata;
                    reg_read_d = 1'b0;
                    state_d    = R_REL;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            R_REL: begin
                if (!reg_valid) begin
                    finish = 1'b1;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            RESP: begin
                rsp_valid_d = 1'b0;
                rsp_rnw_d   = 1'b0;
                rsp_data_d  = '0;
                rsp_err_d   = 1'b0;
                reg_bus_d   = '0;
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (finish) begin
            reg_bus_d   = '0;
            rsp_valid_d = 1'b1;
            rsp_rnw_d   = lat_rnw;
            rsp_err_d   = 1'b0;
            state_d     = RESP;
        end

        if (abort) begin
            reg_read_d  = 1'b0;
            reg_write_d = 1'b0;
            reg_bus_d   = '0;
            rsp_valid_d = 1'b1;
            rsp_rnw_d   = lat_rnw;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
            state_d     = RESP;
        end

        if (state_d != state) begin
            cnt_d = '0;
        end else if (state == W_ADDR || state == W_DATA ||
                     state == R_ADDR || state == R_REL) begin
            cnt_d = cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_reg_access_master.sv
module tb_reg_access_master;

    logic       clk;
    logic       nRst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rnw;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [7:0] reg_bus;
    logic       reg_read;
    logic       reg_write;
    logic [7:0] reg_rdata;
    logic       reg_valid;
    logic       rsp_valid;
    logic       rsp_rnw;
    logic [7:0] rsp_data;
    logic       rsp_err;

    int checks = 0;
    int errors = 0;
    int rsp_count = 0;

    // Responder configuration, set by the stimulus sequence.
    bit ack_en    = 1'b1;
    int ack_delay = 1;

    reg_access_master #(
        .TIMEOUT  (16),
        .MAX_ADDR (8'd254)
    ) dut (
        .clk       (clk),
        .nRst      (nRst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rnw   (cmd_rnw),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .reg_bus   (reg_bus),
        .reg_read  (reg_read),
        .reg_write (reg_write),
        .reg_rdata (reg_rdata),
        .reg_valid (reg_valid),
        .rsp_valid (rsp_valid),
        .rsp_rnw   (rsp_rnw),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register block model with registered acknowledge: raises reg_valid
    // after seeing a strobe for ack_delay edges, drops it once the strobe is
    // released, and stores write data on the edge where it sees write low.
    logic [7:0] mem [256];
    logic [7:0] r_addr;
    logic       r_wr;
    int         wait_cnt;

    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            reg_valid <= 1'b0;
            reg_rdata <= 8'h00;
            r_addr    <= 8'h00;
            r_wr      <= 1'b0;
            wait_cnt  <= 0;
        end else if (!reg_valid) begin
            if (reg_read || reg_write) begin
                wait_cnt <= wait_cnt + 1;
                if (ack_en && (wait_cnt + 1 >= ack_delay)) begin
                    reg_valid <= 1'b1;
                    r_addr    <= reg_bus;
                    r_wr      <= reg_write;
                    reg_rdata <= reg_read ? mem[reg_bus] : 8'h00;
                end
            end else begin
                wait_cnt <= 0;
            end
        end else if (!reg_read && !reg_write) begin
            reg_valid <= 1'b0;
            wait_cnt  <= 0;
            if (r_wr) mem[r_addr] <= reg_bus;
        end
    end

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) rsp_count <= rsp_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One command from issue to response. Called at a negative edge; returns
    // at the negative edge one cycle after the response pulse.
    task automatic do_cmd(input string tag, input logic rnw, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_data,
                          input logic exp_err, input int exp_lat,
                          input int exp_strobes, input bit keep);
        int n;
        int k;
        int strobes;
        int overlap;
        int bus_bad;
        cmd_valid = 1'b1;
        cmd_rnw   = rnw;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (!keep) cmd_valid = 1'b0;
        check({tag, "_busy"}, 32'(cmd_ready), 32'd0);
        k = 0;
        strobes = 0;
        overlap = 0;
        bus_bad = 0;
        while (rsp_valid !== 1'b1 && k < 40) begin
            if (reg_read && reg_write) overlap++;
            if (reg_read || reg_write) strobes++;
            if (!rnw && !reg_write && reg_valid && reg_bus !== wdata) bus_bad++;
            @(negedge clk);
            k++;
        end
        check({tag, "_lat"}, 32'(k), 32'(exp_lat));
        check({tag, "_strobes"}, 32'(strobes), 32'(exp_strobes));
        check({tag, "_overlap"}, 32'(overlap), 32'd0);
        check({tag, "_bushold"}, 32'(bus_bad), 32'd0);
        check({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, "_rnw"}, 32'(rsp_rnw), 32'(rnw));
        @(negedge clk);
        check({tag, "_after"}, 32'({rsp_valid, cmd_ready}), 32'b01);
    endtask

    initial begin
        int base;
        int seen;
        nRst      = 1'b0;
        cmd_valid = 1'b0;
        cmd_rnw   = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({cmd_ready, reg_read, reg_write, reg_bus, rsp_valid, rsp_rnw, rsp_data, rsp_err}),
              32'({1'b1, 21'b0}));
        nRst = 1'b1;
        @(negedge clk);

        // Basic write then read-back, compliant responder.
        do_cmd("wr_10", 1'b0, 8'h10, 8'hA5, 8'h00, 1'b0, 4, 2, 1'b0);
        do_cmd("rd_10", 1'b1, 8'h10, 8'h00, 8'hA5, 1'b0, 4, 2, 1'b0);

        // Out-of-range address: no strobe, immediate error response.
        do_cmd("rd_ff", 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 0, 0, 1'b0);
        // Highest legal address still goes out on the bus.
        do_cmd("wr_fe", 1'b0, 8'hFE, 8'h5C, 8'h00, 1'b0, 4, 2, 1'b0);

        // Responder never acknowledges: strobe held TIMEOUT cycles.
        ack_en = 1'b0;
        do_cmd("rd_to", 1'b1, 8'h03, 8'h00, 8'h00, 1'b1, 16, 16, 1'b0);
        ack_en = 1'b1;

        // Slow responder: 5-cycle acknowledge delay.
        ack_delay = 5;
        do_cmd("wr_slow", 1'b0, 8'h00, 8'h3C, 8'h00, 1'b0, 8, 6, 1'b0);
        do_cmd("rd_slow", 1'b1, 8'h00, 8'h00, 8'h3C, 1'b0, 8, 6, 1'b0);
        ack_delay = 1;

        // Reset asserted while the write strobe is up.
        cmd_valid = 1'b1;
        cmd_rnw   = 1'b0;
        cmd_addr  = 8'h20;
        cmd_wdata = 8'h77;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rst_pre_write", 32'(reg_write), 32'd1);
        base = rsp_count;
        #2 nRst = 1'b0;
        #1;
        check("rst_async_outputs", 32'({reg_write, cmd_ready, reg_bus}), 32'({1'b0, 1'b1, 8'h00}));
        @(negedge clk);
        nRst = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        check("rst_no_rsp", 32'(seen + rsp_count - base), 32'd0);
        do_cmd("wr_20", 1'b0, 8'h20, 8'h5A, 8'h00, 1'b0, 4, 2, 1'b0);
        do_cmd("rd_20", 1'b1, 8'h20, 8'h00, 8'h5A, 1'b0, 4, 2, 1'b0);

        // Back-to-back with cmd_valid held high throughout.
        base = rsp_count;
        do_cmd("b2b_w0", 1'b0, 8'h30, 8'h11, 8'h00, 1'b0, 4, 2, 1'b1);
        do_cmd("b2b_w1", 1'b0, 8'h31, 8'h22, 8'h00, 1'b0, 4, 2, 1'b1);
        do_cmd("b2b_r0", 1'b1, 8'h30, 8'h00, 8'h11, 1'b0, 4, 2, 1'b1);
        do_cmd("b2b_r1", 1'b1, 8'h31, 8'h00, 8'h22, 1'b0, 4, 2, 1'b1);
        cmd_valid = 1'b0;
        check("b2b_rsp_count", 32'(rsp_count - base), 32'd4);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
